// File: rtl/life_mon_pkg.sv
// Shared types and default thresholds for the life-support alarm/escalation monitor.
package life_mon_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_WARN   = 2'd1,
    ST_CRIT   = 2'd2,
    ST_EVAC   = 2'd3
  } state_t;

  localparam int N_DEF         = 32;
  localparam int DEB_DEF       = 3;
  localparam int TEMP_WARN_DEF = 80;
  localparam int TEMP_CRIT_DEF = 95;
  localparam int O2_WARN_DEF   = 50;
  localparam int O2_CRIT_DEF   = 10;
  localparam int PWR_WARN_DEF  = 20;
  localparam int SH_WARN_DEF   = 30;
  localparam int EVAC_CYC_DEF  = 16;

  localparam int CNT_W = 8;
  localparam int EVT_W = 16;

  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    sat_inc = (v == {EVT_W{1'b1}}) ? v : v + EVT_W'(1);
  endfunction

endpackage

// File: rtl/life_mon_debounce.sv
// Consecutive-cycle debouncer: confirmed when cond has been true on DEB consecutive edges.
module life_mon_debounce
#(
  parameter int DEB = 3
)(
  input  logic clk,
  input  logic rst,
  input  logic cond,
  output logic confirmed
);

  localparam logic [3:0] CNT_MAX = 4'(DEB - 1);

  logic [3:0] cnt_r;

  // Run-length counter, saturating at DEB-1 and cleared whenever cond drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 4'd0;
    end else if (!cond) begin
      cnt_r <= 4'd0;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign confirmed = cond & (cnt_r == CNT_MAX);

endmodule

// File: rtl/life_support_monitor.sv
// Alarm/escalation stage: debounced NORMAL/WARN/CRIT/EVAC FSM with registered outputs.
// Define LIFE_MON_EVAC_EN to enable the CRIT->EVAC countdown; otherwise CRIT only recovers.
module life_support_monitor
  import life_mon_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int DEB       = DEB_DEF,
  parameter int TEMP_WARN = TEMP_WARN_DEF,
  parameter int TEMP_CRIT = TEMP_CRIT_DEF,
  parameter int O2_WARN   = O2_WARN_DEF,
  parameter int O2_CRIT   = O2_CRIT_DEF,
  parameter int PWR_WARN  = PWR_WARN_DEF,
  parameter int SH_WARN   = SH_WARN_DEF,
  parameter int EVAC_CYC  = EVAC_CYC_DEF
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     shield,
  input  logic [N-1:0]     temp,
  input  logic [N-1:0]     pwr,
  input  logic [N-1:0]     o2,
  input  logic             fatal,
  input  logic             ack,
  output logic [1:0]       state,
  output logic             alarm,
  output logic             o2sup_req,
  output logic             chrg_req,
  output logic             evac,
  output logic [CNT_W-1:0] countdown,
  output logic [EVT_W-1:0] crit_events
);

  localparam logic [3:0] DEB_MAX = 4'(DEB - 1);

  logic crit_c_s, warn_c_s, clear_c_s, o2_low_s, pwr_low_s;
  logic crit_conf_s, warn_conf_s, clear_conf_s, calm_conf_s;
  logic evac_go_s, enter_crit_s, sil_nxt_s, alarm_nxt_s;
  logic [3:0] calm_cnt_r;
  state_t state_r, state_nxt_s;
  logic silenced_r, alarm_r, o2sup_r, chrg_r;
  logic [EVT_W-1:0] crit_events_r;

  assign o2_low_s  = o2 < N'(O2_WARN);
  assign pwr_low_s = pwr < N'(PWR_WARN);
  assign crit_c_s  = fatal | (o2 < N'(O2_CRIT)) | (temp >= N'(TEMP_CRIT));
  assign warn_c_s  = (temp >= N'(TEMP_WARN)) | o2_low_s | pwr_low_s | (shield < N'(SH_WARN));
  assign clear_c_s = ~crit_c_s & ~warn_c_s;

  life_mon_debounce #(.DEB(DEB)) u_crit_deb (
    .clk(clk), .rst(rst), .cond(crit_c_s), .confirmed(crit_conf_s)
  );
  life_mon_debounce #(.DEB(DEB)) u_warn_deb (
    .clk(clk), .rst(rst), .cond(warn_c_s), .confirmed(warn_conf_s)
  );
  life_mon_debounce #(.DEB(DEB)) u_clear_deb (
    .clk(clk), .rst(rst), .cond(clear_c_s), .confirmed(clear_conf_s)
  );

  // Recovery out of CRIT needs DEB consecutive edges with crit_c low, even if warn_c persists.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      calm_cnt_r <= 4'd0;
    end else if (crit_c_s) begin
      calm_cnt_r <= 4'd0;
    end else if (calm_cnt_r != DEB_MAX) begin
      calm_cnt_r <= calm_cnt_r + 4'd1;
    end else begin
      calm_cnt_r <= calm_cnt_r;
    end
  end

  assign calm_conf_s = ~crit_c_s & (calm_cnt_r == DEB_MAX);

`ifdef LIFE_MON_EVAC_EN
  localparam logic [CNT_W-1:0] EVAC_LOAD = CNT_W'(EVAC_CYC);

  logic [CNT_W-1:0] cd_r, cd_nxt_s;
  logic             evac_r;

  assign evac_go_s = (cd_r == {CNT_W{1'b0}});

  // Countdown loads on CRIT entry, ticks down while CRIT persists, and is zero elsewhere.
  always_comb begin
    cd_nxt_s = {CNT_W{1'b0}};
    if (enter_crit_s) begin
      cd_nxt_s = EVAC_LOAD;
    end else if ((state_r == ST_CRIT) && (state_nxt_s == ST_CRIT) && !evac_go_s) begin
      cd_nxt_s = cd_r - CNT_W'(1);
    end else if (state_nxt_s == ST_CRIT) begin
      cd_nxt_s = cd_r;
    end else begin
      cd_nxt_s = {CNT_W{1'b0}};
    end
  end

  // Countdown and evacuation flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd_r   <= {CNT_W{1'b0}};
      evac_r <= 1'b0;
    end else begin
      cd_r   <= cd_nxt_s;
      evac_r <= (state_nxt_s == ST_EVAC);
    end
  end

  assign countdown = cd_r;
  assign evac      = evac_r;
`else
  logic unused_evac_s;

  assign unused_evac_s = ^(CNT_W'(EVAC_CYC));
  assign evac_go_s     = 1'b0;
  assign countdown     = {CNT_W{1'b0}};
  assign evac          = 1'b0;
`endif

  // Next-state decode; crit confirmation outranks warn/clear, countdown expiry outranks recovery.
  always_comb begin
    state_nxt_s  = state_r;
    enter_crit_s = 1'b0;
    case (state_r)
      ST_NORMAL: begin
        if (crit_conf_s) begin
          state_nxt_s  = ST_CRIT;
          enter_crit_s = 1'b1;
        end else if (warn_conf_s) begin
          state_nxt_s = ST_WARN;
        end else begin
          state_nxt_s = ST_NORMAL;
        end
      end
      ST_WARN: begin
        if (crit_conf_s) begin
          state_nxt_s  = ST_CRIT;
          enter_crit_s = 1'b1;
        end else if (clear_conf_s) begin
          state_nxt_s = ST_NORMAL;
        end else begin
          state_nxt_s = ST_WARN;
        end
      end
      ST_CRIT: begin
        if (evac_go_s) begin
          state_nxt_s = ST_EVAC;
        end else if (calm_conf_s) begin
          state_nxt_s = ST_WARN;
        end else begin
          state_nxt_s = ST_CRIT;
        end
      end
      ST_EVAC: state_nxt_s = ST_EVAC;
      default: state_nxt_s = ST_NORMAL;
    endcase
  end

  // Silence tracking and alarm value as seen alongside the next state.
  always_comb begin
    sil_nxt_s   = silenced_r;
    alarm_nxt_s = 1'b0;
    if (state_nxt_s != state_r) begin
      sil_nxt_s = 1'b0;
    end else if (ack && ((state_r == ST_WARN) || (state_r == ST_CRIT))) begin
      sil_nxt_s = 1'b1;
    end else begin
      sil_nxt_s = silenced_r;
    end
    if (state_nxt_s == ST_EVAC) begin
      alarm_nxt_s = 1'b1;
    end else begin
      alarm_nxt_s = (state_nxt_s != ST_NORMAL) & ~sil_nxt_s;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_NORMAL;
      silenced_r    <= 1'b0;
      alarm_r       <= 1'b0;
      o2sup_r       <= 1'b0;
      chrg_r        <= 1'b0;
      crit_events_r <= {EVT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      silenced_r <= sil_nxt_s;
      alarm_r    <= alarm_nxt_s;
      o2sup_r    <= (state_nxt_s != ST_NORMAL) & o2_low_s;
      chrg_r     <= pwr_low_s;
      if (enter_crit_s) begin
        crit_events_r <= sat_inc(crit_events_r);
      end else begin
        crit_events_r <= crit_events_r;
      end
    end
  end

  assign state       = state_r;
  assign alarm       = alarm_r;
  assign o2sup_req   = o2sup_r;
  assign chrg_req    = chrg_r;
  assign crit_events = crit_events_r;

endmodule

// File: tb/tb_life_support_monitor.sv
// Self-checking bench for life_support_monitor: vector table, hand sequences, random vs reference model.
module tb_life_support_monitor;

`ifdef LIFE_MON_EVAC_EN
  localparam bit EVAC_EN = 1'b1;
`else
  localparam bit EVAC_EN = 1'b0;
`endif
  localparam int DEB = 3;
  localparam int EVAC_CYC = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] shield, temp, pwr, o2;
  logic        fatal, ack;
  logic [1:0]  state;
  logic        alarm, o2sup_req, chrg_req, evac;
  logic [7:0]  countdown;
  logic [15:0] crit_events;

  int checks = 0;
  int failures = 0;

  // reference model state (plain integers, unbounded run lengths)
  int m_state, m_cd, m_events, run_crit, run_warn, run_clear, run_calm;
  bit m_sil, m_alarm, m_o2sup, m_chrg, m_evac;

  typedef struct {
    int temp; int o2; int pwr; int shield; bit fatal; bit ack;
    int ncyc; int st; int alm; int o2s; int chg;
  } vec_t;
  vec_t tbl[$];

  life_support_monitor dut (
    .clk(clk), .rst(rst), .shield(shield), .temp(temp), .pwr(pwr), .o2(o2),
    .fatal(fatal), .ack(ack), .state(state), .alarm(alarm), .o2sup_req(o2sup_req),
    .chrg_req(chrg_req), .evac(evac), .countdown(countdown), .crit_events(crit_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_cd = 0; m_events = 0;
    run_crit = 0; run_warn = 0; run_clear = 0; run_calm = 0;
    m_sil = 0; m_alarm = 0; m_o2sup = 0; m_chrg = 0; m_evac = 0;
  endtask

  task automatic model_edge();
    bit crit, warn, clr, cc, cw, ccl, cn;
    int ns;
    crit = fatal || (o2 < 32'd10) || (temp >= 32'd95);
    warn = (temp >= 32'd80) || (o2 < 32'd50) || (pwr < 32'd20) || (shield < 32'd30);
    clr  = !crit && !warn;
    run_crit  = crit ? run_crit + 1 : 0;
    run_warn  = warn ? run_warn + 1 : 0;
    run_clear = clr ? run_clear + 1 : 0;
    run_calm  = !crit ? run_calm + 1 : 0;
    cc = run_crit >= DEB; cw = run_warn >= DEB; ccl = run_clear >= DEB; cn = run_calm >= DEB;
    ns = m_state;
    if (m_state == 0) ns = cc ? 2 : (cw ? 1 : 0);
    else if (m_state == 1) ns = cc ? 2 : (ccl ? 0 : 1);
    else if (m_state == 2) ns = (EVAC_EN && m_cd == 0) ? 3 : (cn ? 1 : 2);
    if (ns == 2 && m_state != 2) begin
      m_cd = EVAC_CYC;
      if (m_events < 65535) m_events++;
    end else if (ns == 2) begin
      if (m_cd > 0) m_cd--;
    end else begin
      m_cd = 0;
    end
    if (ns != m_state) m_sil = 0;
    else if (ack && (m_state == 1 || m_state == 2)) m_sil = 1;
    m_alarm = (ns == 3) ? 1'b1 : (ns != 0 && !m_sil);
    m_o2sup = (ns != 0) && (o2 < 32'd50);
    m_chrg  = pwr < 32'd20;
    m_evac  = ns == 3;
    m_state = ns;
  endtask

  task automatic check_all();
    chk("state", int'(state), m_state);
    chk("alarm", int'(alarm), int'(m_alarm));
    chk("o2sup_req", int'(o2sup_req), int'(m_o2sup));
    chk("chrg_req", int'(chrg_req), int'(m_chrg));
    chk("evac", int'(evac), int'(m_evac));
    chk("countdown", int'(countdown), EVAC_EN ? m_cd : 0);
    chk("crit_events", int'(crit_events), m_events);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_in(input int t, input int ox, input int p, input int s, input bit f, input bit a);
    temp = 32'(t); o2 = 32'(ox); pwr = 32'(p); shield = 32'(s); fatal = f; ack = a;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_in(20, 200, 100, 100, 1'b0, 1'b0);
    m_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b1;
  endtask

  function automatic logic [31:0] pick(input int a, input int b, input int c);
    case ($urandom_range(0, 3))
      0: pick = 32'(a);
      1: pick = 32'(b);
      2: pick = 32'(c);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    set_in(20, 200, 100, 100, 1'b0, 1'b0);
    // temp, o2, pwr, shield, fatal, ack, ncyc -> state, alarm, o2sup, chrg
    tbl.push_back('{20, 200, 100, 100, 0, 0, 50, 0, 0, 0, 0});
    tbl.push_back('{20,  40, 100, 100, 0, 0,  2, 0, 0, 0, 0});
    tbl.push_back('{20,  40, 100, 100, 0, 0,  1, 1, 1, 1, 0});
    tbl.push_back('{20,  40, 100, 100, 0, 1,  1, 1, 0, 1, 0});
    tbl.push_back('{20, 200, 100, 100, 0, 0,  2, 1, 0, 0, 0});
    tbl.push_back('{20, 200, 100, 100, 0, 0,  1, 0, 0, 0, 0});
    tbl.push_back('{96, 200, 100, 100, 0, 0,  2, 0, 0, 0, 0});
    tbl.push_back('{96, 200, 100, 100, 0, 0,  1, 2, 1, 0, 0});
    tbl.push_back('{90, 200, 100, 100, 0, 0,  3, 1, 1, 0, 0});
    tbl.push_back('{20, 200,  10, 100, 0, 0,  3, 1, 1, 0, 1});
    tbl.push_back('{20, 200, 100, 100, 1, 0,  2, 1, 1, 0, 0});
    tbl.push_back('{20, 200, 100, 100, 0, 0,  2, 1, 1, 0, 0});
    tbl.push_back('{20, 200, 100, 100, 0, 0,  1, 0, 0, 0, 0});
    tbl.push_back('{20,  40, 100, 100, 0, 0,  3, 1, 1, 1, 0});
    tbl.push_back('{20,  40, 100, 100, 0, 1,  1, 1, 0, 1, 0});
    tbl.push_back('{20,   5, 100, 100, 0, 0,  2, 1, 0, 1, 0});
    tbl.push_back('{20,   5, 100, 100, 0, 0,  1, 2, 1, 1, 0});

    do_reset();
    foreach (tbl[i]) begin
      set_in(tbl[i].temp, tbl[i].o2, tbl[i].pwr, tbl[i].shield, tbl[i].fatal, tbl[i].ack);
      for (int c = 0; c < tbl[i].ncyc; c++) cycle();
      chk($sformatf("tbl%0d_state", i), int'(state), tbl[i].st);
      chk($sformatf("tbl%0d_alarm", i), int'(alarm), tbl[i].alm);
      chk($sformatf("tbl%0d_o2sup", i), int'(o2sup_req), tbl[i].o2s);
      chk($sformatf("tbl%0d_chrg", i), int'(chrg_req), tbl[i].chg);
    end
    chk("crit_events_two", int'(crit_events), 2);
    chk("countdown_entry", int'(countdown), EVAC_EN ? EVAC_CYC : 0);

    // ack silences CRIT
    set_in(20, 5, 100, 100, 1'b0, 1'b1);
    cycle();
    chk("crit_ack_alarm", int'(alarm), 0);
    ack = 1'b0;
`ifdef LIFE_MON_EVAC_EN
    for (int c = 0; c < 15; c++) cycle();
    chk("pre_evac_state", int'(state), 2);
    cycle();
    chk("evac_state", int'(state), 3);
    chk("evac_flag", int'(evac), 1);
    chk("evac_alarm", int'(alarm), 1);
    ack = 1'b1;
    set_in(20, 200, 100, 100, 1'b0, 1'b1);
    for (int c = 0; c < 5; c++) cycle();
    chk("evac_absorb", int'(state), 3);
    chk("evac_ack_alarm", int'(alarm), 1);
`else
    for (int c = 0; c < 100; c++) cycle();
    chk("crit_hold_state", int'(state), 2);
    chk("crit_hold_evac", int'(evac), 0);
`endif

    // async reset mid-countdown
    do_reset();
    set_in(96, 200, 100, 100, 1'b0, 1'b0);
    for (int c = 0; c < 12; c++) cycle();
    chk("mid_state", int'(state), 2);
    chk("mid_countdown", int'(countdown), EVAC_EN ? 7 : 0);
    #2 rst = 1'b0;
    #1;
    m_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst = 1'b1;

    // randomized against the model, with periodic resets
    for (int r = 0; r < 3000; r++) begin
      if (r % 300 == 0) do_reset();
      if ($urandom_range(0, 5) == 0) temp = pick(20, 85, 96);
      if ($urandom_range(0, 5) == 0) o2 = pick(200, 40, 5);
      if ($urandom_range(0, 5) == 0) pwr = pick(100, 10, 20);
      if ($urandom_range(0, 5) == 0) shield = pick(100, 29, 30);
      if ($urandom_range(0, 5) == 0) fatal = ($urandom_range(0, 7) == 0);
      ack = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
